// File: rtl/md_load_ctl_if.sv
// Signal bundle between the microcode sequencer/memory/spy side and the MD load controller.
interface md_load_ctl_if;
  logic        state_alu;
  logic        memrq;
  logic        mem_ack;
  logic        destmdr;
  logic        srcmd;
  logic        spy_ldmdh_req;
  logic        spy_ldmdl_req;
  logic        loadmd;
  logic        md_memrq;
  logic        ldmdh;
  logic        ldmdl;
  logic        spy_ack;
  logic        memwait;
  logic        mem_timeout;
  logic        mem_overrun;
  logic [15:0] load_count;
  logic [15:0] cancel_count;

  modport master (
    output state_alu, memrq, mem_ack, destmdr, srcmd, spy_ldmdh_req, spy_ldmdl_req,
    input  loadmd, md_memrq, ldmdh, ldmdl, spy_ack, memwait, mem_timeout, mem_overrun,
    input  load_count, cancel_count
  );

  modport slave (
    input  state_alu, memrq, mem_ack, destmdr, srcmd, spy_ldmdh_req, spy_ldmdl_req,
    output loadmd, md_memrq, ldmdh, ldmdl, spy_ack, memwait, mem_timeout, mem_overrun,
    output load_count, cancel_count
  );
endinterface

// File: rtl/md_load_ctl.sv
// MD register write sequencer: one outstanding read, load strobe 1 cycle after mem_ack, spy/ALU arbitration.
// memwait stalls the sequencer while MD is sourced during a read. Load/cancel counters built only with MD_LOAD_STATS_EN.
module md_load_ctl #(
  parameter int TMO_W     = 8,
  parameter int TMO_LIMIT = 200
) (
  input  logic         clk,
  input  logic         reset,
  md_load_ctl_if.slave md
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, LOAD} state_e;

  state_e           state_q, state_d;
  logic [TMO_W-1:0] cnt_q, cnt_d;
  logic             cancel_q, cancel_d;
  logic             pend_h_q, pend_h_d;
  logic             pend_l_q, pend_l_d;
  logic             loadmd_q, loadmd_d;
  logic             ldmdh_q, ldmdh_d;
  logic             ldmdl_q, ldmdl_d;
  logic             spy_ack_q, spy_ack_d;
  logic             tmo_q, tmo_d;
  logic             ovr_q, ovr_d;

  logic alu_wr;
  logic spy_ok, req_h, req_l, grant_h, grant_l;

  assign alu_wr = md.state_alu & md.destmdr;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cancel_d = cancel_q;
    tmo_d    = tmo_q;
    ovr_d    = ovr_q;
    case (state_q)
      IDLE: begin
        if (md.memrq) begin
          state_d = RD_WAIT;
          cnt_d   = '0;
        end
      end
      RD_WAIT: begin
        cnt_d = cnt_q + TMO_W'(1);
        if (alu_wr)   cancel_d = 1'b1;
        if (md.memrq) ovr_d    = 1'b1;
        // An ALU write in the ack cycle also cancels: the load would land after it.
        if (md.mem_ack) begin
          state_d  = (cancel_q | alu_wr) ? IDLE : LOAD;
          cancel_d = 1'b0;
        end else if (cnt_q == TMO_W'(TMO_LIMIT - 1)) begin
          state_d  = IDLE;
          tmo_d    = 1'b1;
          cancel_d = 1'b0;
        end
      end
      LOAD: begin
        if (md.memrq) begin
          state_d = RD_WAIT;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Spy writes only get MD when neither memory nor the ALU will touch it.
  assign spy_ok  = (state_d == IDLE) & ~md.memrq & ~alu_wr;
  assign req_h   = pend_h_q | md.spy_ldmdh_req;
  assign req_l   = pend_l_q | md.spy_ldmdl_req;
  assign grant_h = spy_ok & req_h;
  assign grant_l = spy_ok & ~req_h & req_l;

  always_comb begin
    pend_h_d  = req_h & ~grant_h;
    pend_l_d  = req_l & ~grant_l;
    loadmd_d  = (state_d == LOAD);
    ldmdh_d   = grant_h;
    ldmdl_d   = grant_l;
    spy_ack_d = grant_h | grant_l;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      cancel_q  <= 1'b0;
      pend_h_q  <= 1'b0;
      pend_l_q  <= 1'b0;
      loadmd_q  <= 1'b0;
      ldmdh_q   <= 1'b0;
      ldmdl_q   <= 1'b0;
      spy_ack_q <= 1'b0;
      tmo_q     <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cancel_q  <= cancel_d;
      pend_h_q  <= pend_h_d;
      pend_l_q  <= pend_l_d;
      loadmd_q  <= loadmd_d;
      ldmdh_q   <= ldmdh_d;
      ldmdl_q   <= ldmdl_d;
      spy_ack_q <= spy_ack_d;
      tmo_q     <= tmo_d;
      ovr_q     <= ovr_d;
    end
  end

  assign md.loadmd      = loadmd_q;
  assign md.md_memrq    = loadmd_q;
  assign md.ldmdh       = ldmdh_q;
  assign md.ldmdl       = ldmdl_q;
  assign md.spy_ack     = spy_ack_q;
  assign md.memwait     = (state_q == RD_WAIT) & md.srcmd;
  assign md.mem_timeout = tmo_q;
  assign md.mem_overrun = ovr_q;

`ifdef MD_LOAD_STATS_EN
  logic [15:0] load_cnt_q, cancel_cnt_q;
  logic        discard;

  // RD_WAIT falls straight to IDLE only on a cancelled ack or a timeout.
  assign discard = (state_q == RD_WAIT) & (state_d == IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load_cnt_q   <= '0;
      cancel_cnt_q <= '0;
    end else begin
      if (loadmd_d) load_cnt_q   <= load_cnt_q + 16'd1;
      if (discard)  cancel_cnt_q <= cancel_cnt_q + 16'd1;
    end
  end

  assign md.load_count   = load_cnt_q;
  assign md.cancel_count = cancel_cnt_q;
`else
  assign md.load_count   = '0;
  assign md.cancel_count = '0;
`endif

endmodule

// File: tb/tb_md_load_ctl.sv
// Directed bench for md_load_ctl; timeout limit shortened to 10 cycles.
module tb_md_load_ctl;

`ifdef MD_LOAD_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  md_load_ctl_if m ();

  md_load_ctl #(.TMO_W(8), .TMO_LIMIT(10)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (m)
  );

  always #5 clk = ~clk;

  // Cycle n is the interval after the n-th posedge; drive and sample at edge+1.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m.state_alu = 0; m.memrq = 0; m.mem_ack = 0; m.destmdr = 0;
    m.srcmd = 0; m.spy_ldmdh_req = 0; m.spy_ldmdl_req = 0;
  endtask

  task automatic test_reset();
    logic [7:0] outs;
    clear_inputs();
    m.srcmd = 1;
    reset = 1;
    tick(); tick();
    outs = {m.loadmd, m.md_memrq, m.ldmdh, m.ldmdl, m.spy_ack, m.memwait, m.mem_timeout, m.mem_overrun};
    n_chk++;
    if (outs !== 8'h00) begin n_fail++; $display("FAIL reset.outs: got %b want 00000000", outs); end
    n_chk++;
    if ({m.load_count, m.cancel_count} !== 32'h0) begin
      n_fail++; $display("FAIL reset.counts: got %h/%h want 0/0", m.load_count, m.cancel_count);
    end
    reset = 0;
    m.srcmd = 0;
    tick();
  endtask

  task automatic test_basic_read();
    logic [15:0] exp_cnt;
    m.srcmd = 1;
    m.memrq = 1;
    tick();
    m.memrq = 0;
    for (int c = 1; c <= 8; c++) begin
      m.mem_ack = (c == 5);
      n_chk++;
      if (m.loadmd !== (c == 6) || m.md_memrq !== (c == 6)) begin
        n_fail++; $display("FAIL basic.loadmd c%0d: got %b/%b want %b", c, m.loadmd, m.md_memrq, (c == 6));
      end
      n_chk++;
      if (m.memwait !== (c <= 5)) begin
        n_fail++; $display("FAIL basic.memwait c%0d: got %b want %b", c, m.memwait, (c <= 5));
      end
      tick();
    end
    m.mem_ack = 0;
    m.srcmd = 0;
    exp_cnt = STATS ? 16'd1 : 16'd0;
    n_chk++;
    if (m.load_count !== exp_cnt) begin
      n_fail++; $display("FAIL basic.load_count: got %0d want %0d", m.load_count, exp_cnt);
    end
  endtask

  task automatic test_cancel();
    logic [15:0] exp_cnt;
    m.srcmd = 1;
    m.memrq = 1;
    tick();
    m.memrq = 0;
    for (int c = 1; c <= 7; c++) begin
      m.state_alu = (c == 2);
      m.destmdr   = (c == 2);
      m.mem_ack   = (c == 4);
      n_chk++;
      if (m.loadmd !== 1'b0) begin n_fail++; $display("FAIL cancel.loadmd c%0d: got %b want 0", c, m.loadmd); end
      n_chk++;
      if (m.memwait !== (c <= 4)) begin
        n_fail++; $display("FAIL cancel.memwait c%0d: got %b want %b", c, m.memwait, (c <= 4));
      end
      tick();
    end
    clear_inputs();
    exp_cnt = STATS ? 16'd1 : 16'd0;
    n_chk++;
    if (m.cancel_count !== exp_cnt) begin
      n_fail++; $display("FAIL cancel.cancel_count: got %0d want %0d", m.cancel_count, exp_cnt);
    end
  endtask

  task automatic test_timeout();
    logic [15:0] exp_cnt;
    m.srcmd = 1;
    m.memrq = 1;
    tick();
    m.memrq = 0;
    for (int c = 1; c <= 14; c++) begin
      n_chk++;
      if (m.memwait !== (c <= 10)) begin
        n_fail++; $display("FAIL timeout.memwait c%0d: got %b want %b", c, m.memwait, (c <= 10));
      end
      n_chk++;
      if (m.mem_timeout !== (c >= 11)) begin
        n_fail++; $display("FAIL timeout.flag c%0d: got %b want %b", c, m.mem_timeout, (c >= 11));
      end
      n_chk++;
      if (m.loadmd !== 1'b0) begin n_fail++; $display("FAIL timeout.loadmd c%0d: got %b want 0", c, m.loadmd); end
      tick();
    end
    m.srcmd = 0;
    exp_cnt = STATS ? 16'd2 : 16'd0;
    n_chk++;
    if (m.cancel_count !== exp_cnt) begin
      n_fail++; $display("FAIL timeout.cancel_count: got %0d want %0d", m.cancel_count, exp_cnt);
    end
  endtask

  task automatic test_spy();
    m.memrq = 1;
    tick();
    m.memrq = 0;
    for (int c = 1; c <= 8; c++) begin
      m.spy_ldmdh_req = (c == 1);
      m.spy_ldmdl_req = (c == 1);
      m.mem_ack       = (c == 3);
      n_chk++;
      if (m.loadmd !== (c == 4)) begin n_fail++; $display("FAIL spy.loadmd c%0d: got %b want %b", c, m.loadmd, (c == 4)); end
      n_chk++;
      if (m.ldmdh !== (c == 5)) begin n_fail++; $display("FAIL spy.ldmdh c%0d: got %b want %b", c, m.ldmdh, (c == 5)); end
      n_chk++;
      if (m.ldmdl !== (c == 6)) begin n_fail++; $display("FAIL spy.ldmdl c%0d: got %b want %b", c, m.ldmdl, (c == 6)); end
      n_chk++;
      if (m.spy_ack !== (c == 5 || c == 6)) begin
        n_fail++; $display("FAIL spy.ack c%0d: got %b want %b", c, m.spy_ack, (c == 5 || c == 6));
      end
      tick();
    end
    // ALU destmdr write outranks a spy request in the same cycle.
    for (int c = 0; c <= 3; c++) begin
      m.spy_ldmdl_req = (c == 0);
      m.state_alu     = (c == 0);
      m.destmdr       = (c == 0);
      n_chk++;
      if (m.ldmdl !== (c == 2) || m.spy_ack !== (c == 2)) begin
        n_fail++; $display("FAIL spy.alu_prio c%0d: got %b/%b want %b", c, m.ldmdl, m.spy_ack, (c == 2));
      end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_cnt;
    m.srcmd = 1;
    m.memrq = 1;
    tick();
    for (int c = 1; c <= 10; c++) begin
      m.memrq   = (c == 2 || c == 4);
      m.mem_ack = (c == 3 || c == 7);
      n_chk++;
      if (m.loadmd !== (c == 4 || c == 8)) begin
        n_fail++; $display("FAIL b2b.loadmd c%0d: got %b want %b", c, m.loadmd, (c == 4 || c == 8));
      end
      n_chk++;
      if (m.mem_overrun !== (c >= 3)) begin
        n_fail++; $display("FAIL b2b.overrun c%0d: got %b want %b", c, m.mem_overrun, (c >= 3));
      end
      n_chk++;
      if (m.memwait !== (c <= 3 || (c >= 5 && c <= 7))) begin
        n_fail++; $display("FAIL b2b.memwait c%0d: got %b want %b", c, m.memwait, (c <= 3 || (c >= 5 && c <= 7)));
      end
      tick();
    end
    clear_inputs();
    exp_cnt = STATS ? 16'd4 : 16'd0;
    n_chk++;
    if (m.load_count !== exp_cnt) begin
      n_fail++; $display("FAIL b2b.load_count: got %0d want %0d", m.load_count, exp_cnt);
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] outs;
    m.srcmd = 1;
    m.memrq = 1;
    tick();
    m.memrq = 0;
    n_chk++;
    if (m.memwait !== 1'b1) begin n_fail++; $display("FAIL areset.pre_memwait: got %b want 1", m.memwait); end
    #2;
    reset = 1;
    #1;
    outs = {m.loadmd, m.md_memrq, m.ldmdh, m.ldmdl, m.spy_ack, m.memwait, m.mem_timeout, m.mem_overrun};
    n_chk++;
    if (outs !== 8'h00) begin n_fail++; $display("FAIL areset.outs: got %b want 00000000", outs); end
    n_chk++;
    if ({m.load_count, m.cancel_count} !== 32'h0) begin
      n_fail++; $display("FAIL areset.counts: got %h/%h want 0/0", m.load_count, m.cancel_count);
    end
    #1;
    reset = 0;
    tick();
    for (int c = 0; c <= 4; c++) begin
      m.mem_ack = (c == 0);
      n_chk++;
      if (m.loadmd !== 1'b0 || m.memwait !== 1'b0) begin
        n_fail++; $display("FAIL areset.after c%0d: got loadmd=%b memwait=%b want 0/0", c, m.loadmd, m.memwait);
      end
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_basic_read();
    test_cancel();
    test_timeout();
    test_spy();
    test_back_to_back();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
